// File: rtl/seg8_capture_if.sv
// Bus bundle for seg8_capture.
// Inputs carry the sampled display strobes and the 1 kHz tick. Outputs carry the reassembled frame.
//   i_pls_1k      one-cycle 1 kHz tick
//   i_seg_d       segment data {dp,g,f,e,d,c,b,a}, active-high
//   i_seg_com     digit commons, active-low one-hot
//   o_bcd8d       last complete frame, digit n in [4n+3:4n]
//   o_dp          decimal point per digit of the last frame
//   o_frame_valid one-cycle pulse when the frame outputs update
//   o_pat_err     last frame contained an undecodable pattern
//   o_stall       scan stopped (timeout)
// The master modport is the side that drives the strobes. The slave modport is the capture block.
interface seg8_capture_if;
  logic        i_pls_1k;
  logic [7:0]  i_seg_d;
  logic [7:0]  i_seg_com;
  logic [31:0] o_bcd8d;
  logic [7:0]  o_dp;
  logic        o_frame_valid;
  logic        o_pat_err;
  logic        o_stall;

  modport master (
    output i_pls_1k, i_seg_d, i_seg_com,
    input  o_bcd8d, o_dp, o_frame_valid, o_pat_err, o_stall
  );

  modport slave (
    input  i_pls_1k, i_seg_d, i_seg_com,
    output o_bcd8d, o_dp, o_frame_valid, o_pat_err, o_stall
  );
endinterface

// File: rtl/seg8_capture.sv
// seg8_capture: receive-side monitor for an 8-digit multiplexed 7-segment display.
// The block registers the segment and common strobes. After a common has been stable long
// enough, it samples the segments, decodes them to BCD, and builds a full scan frame. The
// frame is published as a packed BCD word with decimal points, a pattern-error flag and a
// stall flag.
// Ports:
//   i_clk   system clock
//   i_rstn  asynchronous active-low reset
//   bus     seg8_capture_if.slave (i_pls_1k, i_seg_d, i_seg_com in; frame outputs out)
module seg8_capture #(
  parameter int unsigned SETTLE_CYC = 4,   // stable cycles before sampling, 1..15
  parameter int unsigned TIMEOUT_MS = 16   // ticks without a common change before stall, 1..255
) (
  input logic           i_clk,
  input logic           i_rstn,
  seg8_capture_if.slave bus
);

  localparam logic [3:0] SettleMax  = 4'(SETTLE_CYC);
  localparam logic [7:0] TimeoutMax = 8'(TIMEOUT_MS);

  logic [7:0]  seg_q, seg_d;
  logic [7:0]  com_q, com_d;
  logic [7:0]  com_prev_q, com_prev_d;
  logic [3:0]  settle_q, settle_d;
  logic [7:0]  ms_q, ms_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  shadow_dp_q, shadow_dp_d;
  logic [7:0]  mask_q, mask_d;
  logic        err_acc_q, err_acc_d;
  logic [31:0] bcd_q, bcd_d;
  logic [7:0]  dp_q, dp_d;
  logic        fv_q, fv_d;
  logic        pat_err_q, pat_err_d;
  logic        stall_q, stall_d;

  logic        com_valid;
  logic        com_change;
  logic        sample;
  logic        stall_evt;
  logic        frame_done;
  logic [2:0]  com_idx;
  logic [3:0]  dec_nib;
  logic        dec_bad;

  assign com_valid  = $onehot(~com_q);
  assign com_change = (com_q != com_prev_q);
  assign frame_done = (mask_q == 8'hFF);

  // The strobe fires only on the single cycle where the settle counter steps onto its limit.
  assign sample = !com_change && com_valid && (settle_q == SettleMax - 4'd1);

  // The tick count crosses the timeout exactly once per frozen period.
  assign stall_evt = !com_change && bus.i_pls_1k && (ms_q == TimeoutMax - 8'd1);

  always_comb begin
    com_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!com_q[i]) com_idx = 3'(i);
    end
  end

  always_comb begin
    dec_nib = 4'hE;
    dec_bad = 1'b0;
    case (seg_q[6:0])
      7'h3F:   dec_nib = 4'h0;
      7'h06:   dec_nib = 4'h1;
      7'h5B:   dec_nib = 4'h2;
      7'h4F:   dec_nib = 4'h3;
      7'h66:   dec_nib = 4'h4;
      7'h6D:   dec_nib = 4'h5;
      7'h7D:   dec_nib = 4'h6;
      7'h07:   dec_nib = 4'h7;
      7'h7F:   dec_nib = 4'h8;
      7'h6F:   dec_nib = 4'h9;
      7'h00:   dec_nib = 4'hF;
      default: begin
        dec_nib = 4'hE;
        dec_bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    seg_d       = bus.i_seg_d;
    com_d       = bus.i_seg_com;
    com_prev_d  = com_q;
    settle_d    = settle_q;
    ms_d        = ms_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    mask_d      = mask_q;
    err_acc_d   = err_acc_q;
    bcd_d       = bcd_q;
    dp_d        = dp_q;
    fv_d        = 1'b0;
    pat_err_d   = pat_err_q;
    stall_d     = stall_q;

    if (com_change || !com_valid) begin
      settle_d = '0;
    end else if (settle_q != SettleMax) begin
      settle_d = settle_q + 4'd1;
    end

    // A common change beats a coincident tick.
    if (com_change) begin
      ms_d = '0;
    end else if (bus.i_pls_1k && (ms_q != TimeoutMax)) begin
      ms_d = ms_q + 8'd1;
    end

    if (frame_done) begin
      bcd_d     = shadow_q;
      dp_d      = shadow_dp_q;
      pat_err_d = err_acc_q;
      fv_d      = 1'b1;
    end

    if (frame_done || stall_evt) begin
      mask_d    = '0;
      err_acc_d = 1'b0;
    end

    // A sample is applied after the clear, so it starts the next frame.
    if (sample) begin
      shadow_d[{com_idx, 2'b00} +: 4] = dec_nib;
      shadow_dp_d[com_idx]            = seg_q[7];
      mask_d[com_idx]                 = 1'b1;
      err_acc_d                       = err_acc_d | dec_bad;
    end

    if (com_change && com_valid) begin
      stall_d = 1'b0;
    end else if (stall_evt) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      seg_q       <= '0;
      com_q       <= '0;
      com_prev_q  <= '0;
      settle_q    <= '0;
      ms_q        <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      mask_q      <= '0;
      err_acc_q   <= 1'b0;
      bcd_q       <= '0;
      dp_q        <= '0;
      fv_q        <= 1'b0;
      pat_err_q   <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      seg_q       <= seg_d;
      com_q       <= com_d;
      com_prev_q  <= com_prev_d;
      settle_q    <= settle_d;
      ms_q        <= ms_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      mask_q      <= mask_d;
      err_acc_q   <= err_acc_d;
      bcd_q       <= bcd_d;
      dp_q        <= dp_d;
      fv_q        <= fv_d;
      pat_err_q   <= pat_err_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.o_bcd8d       = bcd_q;
  assign bus.o_dp          = dp_q;
  assign bus.o_frame_valid = fv_q;
  assign bus.o_pat_err     = pat_err_q;
  assign bus.o_stall       = stall_q;

endmodule

// File: tb/tb_seg8_capture.sv
// Testbench for seg8_capture: directed scans plus randomized scans.
// Outputs are compared every cycle against a frame-level model of the display protocol.
module tb_seg8_capture;
  localparam int unsigned S = 4;
  localparam int unsigned T = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  seg8_capture_if bus ();

  seg8_capture #(
    .SETTLE_CYC(S),
    .TIMEOUT_MS(T)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] pat_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [7:0] enc(input int v);
    if (v < 10) return {1'b0, pat_tab[v]};
    return 8'h00;
  endfunction

  function automatic logic [3:0] m_decode(input logic [6:0] p, output logic bad);
    bad = 1'b0;
    if (p == 7'h00) return 4'hF;
    for (int i = 0; i < 10; i++) if (pat_tab[i] == p) return 4'(i);
    bad = 1'b1;
    return 4'hE;
  endfunction

  function automatic logic is_onehot_low(input logic [7:0] c);
    return $countones(~c) == 1;
  endfunction

  // Model: run length of the registered common, digits seen this frame, tick count since change.
  logic [7:0]  m_com_r, m_com_rp, m_seg_r;
  int          m_run, m_ms;
  logic [3:0]  m_dig [8];
  logic [7:0]  m_dpv, m_have;
  logic        m_err, m_pend, m_stall;
  logic [31:0] exp_bcd;
  logic [7:0]  exp_dp;
  logic        exp_fv, exp_err;

  task automatic model_reset();
    m_com_r = '0; m_com_rp = '0; m_seg_r = '0;
    m_run = 0; m_ms = 0;
    for (int i = 0; i < 8; i++) m_dig[i] = '0;
    m_dpv = '0; m_have = '0; m_err = 0; m_pend = 0; m_stall = 0;
    exp_bcd = '0; exp_dp = '0; exp_fv = 0; exp_err = 0;
  endtask

  task automatic model_edge(input logic [7:0] seg_in, input logic [7:0] com_in, input logic pls);
    logic change, strobe, evt, bad;
    logic [3:0] nib;
    int idx;
    change = (m_com_r != m_com_rp);
    strobe = (m_run == S + 1);
    evt = 0;
    idx = 0;
    for (int i = 0; i < 8; i++) if (!m_com_r[i]) idx = i;
    exp_fv = 0;
    if (m_pend) begin
      for (int i = 0; i < 8; i++) exp_bcd[4*i +: 4] = m_dig[i];
      exp_dp = m_dpv; exp_err = m_err; exp_fv = 1;
      m_have = '0; m_err = 0;
    end
    if (change) m_ms = 0;
    else if (pls && m_ms < T) begin
      m_ms++;
      if (m_ms == T) evt = 1;
    end
    if (evt) begin m_have = '0; m_err = 0; end
    if (strobe) begin
      nib = m_decode(m_seg_r[6:0], bad);
      m_dig[idx] = nib; m_dpv[idx] = m_seg_r[7]; m_have[idx] = 1'b1; m_err = m_err | bad;
    end
    if (change && is_onehot_low(m_com_r)) m_stall = 0;
    else if (evt) m_stall = 1;
    m_pend = (m_have == 8'hFF);
    if (!is_onehot_low(com_in)) m_run = 0;
    else if (com_in == m_com_r) m_run = (m_run < 1000) ? m_run + 1 : m_run;
    else m_run = 1;
    m_com_rp = m_com_r; m_com_r = com_in; m_seg_r = seg_in;
  endtask

  int cyc = 0;
  int pls_mode = 0;  // 0: fixed 1-in-16, 1: random 1-in-8, 2: every other cycle
  logic chk_en = 1'b0;
  int fv_cnt = 0;
  logic [31:0] fv_bcd;
  logic [7:0]  fv_dp;
  logic        fv_err;

  task automatic step(input logic [7:0] seg, input logic [7:0] com);
    logic p;
    case (pls_mode)
      0:       p = (cyc % 16 == 15);
      1:       p = ($urandom_range(0, 7) == 0);
      default: p = cyc[0];
    endcase
    bus.i_seg_d = seg; bus.i_seg_com = com; bus.i_pls_1k = p;
    @(posedge clk);
    if (rstn) model_edge(seg, com, p);
    else model_reset();
    cyc++;
    #1;
  endtask

  // Drive digits 0..7 with the given patterns; glitch_d < 0 disables the common glitch.
  task automatic scan(input logic [63:0] segs, input int dwell, input int glitch_d);
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < dwell; c++) begin
        if (d == glitch_d && (c == 8 || c == 9)) step(segs[8*d +: 8], 8'hFC);
        else step(segs[8*d +: 8], ~(8'h01 << d));
      end
    end
  endtask

  task automatic hold(input logic [7:0] seg, input logic [7:0] com, input int n);
    for (int i = 0; i < n; i++) step(seg, com);
  endtask

  always @(negedge clk) begin
    if (rstn && chk_en) begin
      check("o_bcd8d", bus.o_bcd8d, exp_bcd);
      check("o_dp", 32'(bus.o_dp), 32'(exp_dp));
      check("o_frame_valid", 32'(bus.o_frame_valid), 32'(exp_fv));
      check("o_pat_err", 32'(bus.o_pat_err), 32'(exp_err));
      check("o_stall", 32'(bus.o_stall), 32'(m_stall));
      if (bus.o_frame_valid) begin
        fv_cnt++; fv_bcd = bus.o_bcd8d; fv_dp = bus.o_dp; fv_err = bus.o_pat_err;
      end
    end
  end

  task automatic check_frame(input string name, input int fv0, input logic [31:0] bcd,
                             input logic [7:0] dp, input logic err);
    check({name, " frames"}, 32'(fv_cnt - fv0), 32'd1);
    check({name, " bcd"}, fv_bcd, bcd);
    check({name, " dp"}, 32'(fv_dp), 32'(dp));
    check({name, " pat_err"}, 32'(fv_err), 32'(err));
  endtask

  task automatic check_zero(input string name);
    check({name, " bcd"}, bus.o_bcd8d, 32'h0);
    check({name, " dp"}, 32'(bus.o_dp), 32'h0);
    check({name, " fv"}, 32'(bus.o_frame_valid), 32'h0);
    check({name, " pat_err"}, 32'(bus.o_pat_err), 32'h0);
    check({name, " stall"}, 32'(bus.o_stall), 32'h0);
  endtask

  logic [63:0] base, alt, rnd;
  int fv0;

  initial begin
    bus.i_seg_d = '0; bus.i_seg_com = 8'hFF; bus.i_pls_1k = 1'b0;
    model_reset();
    #1 rstn = 1'b0;
    #2 check_zero("reset");
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    chk_en = 1'b1;
    #1;

    for (int d = 0; d < 8; d++) begin
      base[8*d +: 8] = enc(d + 1);
      alt[8*d +: 8]  = enc(8 - d);
    end

    // Plain frame "12345678".
    fv0 = fv_cnt; scan(base, 20, -1); hold(base[63:56], 8'h7F, 4);
    check_frame("t1", fv0, 32'h87654321, 8'h00, 1'b0);

    // Blank digit 3 and dp on digit 5.
    rnd = base; rnd[31:24] = 8'h00; rnd[47:40] = rnd[47:40] | 8'h80;
    fv0 = fv_cnt; scan(rnd, 20, -1); hold(rnd[63:56], 8'h7F, 4);
    check_frame("t2", fv0, 32'h8765F321, 8'h20, 1'b0);

    // Undecodable digit 2, then a clean frame.
    rnd = base; rnd[23:16] = 8'h49;
    fv0 = fv_cnt; scan(rnd, 20, -1); hold(rnd[63:56], 8'h7F, 4);
    check_frame("t3 bad", fv0, 32'h87654E21, 8'h00, 1'b1);
    fv0 = fv_cnt; scan(base, 20, -1); hold(base[63:56], 8'h7F, 4);
    check_frame("t3 clean", fv0, 32'h87654321, 8'h00, 1'b0);

    // Two-cycle common glitch on digit 3.
    fv0 = fv_cnt; scan(base, 20, 3); hold(base[63:56], 8'h7F, 4);
    check_frame("t4", fv0, 32'h87654321, 8'h00, 1'b0);

    // Freeze after five digits, then resume with a different frame.
    fv0 = fv_cnt;
    for (int d = 0; d < 5; d++) hold(alt[8*d +: 8], ~(8'h01 << d), 20);
    pls_mode = 2; hold(alt[39:32], 8'hEF, 40); pls_mode = 0;
    check("t5 stall", 32'(bus.o_stall), 32'd1);
    check("t5 no frame", 32'(fv_cnt - fv0), 32'd0);
    scan(alt, 20, -1); hold(alt[63:56], 8'h7F, 4);
    check("t5 stall cleared", 32'(bus.o_stall), 32'd0);
    check_frame("t5", fv0, 32'h12345678, 8'h00, 1'b0);

    // Asynchronous reset mid-frame.
    for (int d = 0; d < 4; d++) hold(base[8*d +: 8], ~(8'h01 << d), 20);
    #2 rstn = 1'b0;
    #1 check_zero("t6 async");
    step(base[31:24], 8'hF7); step(base[31:24], 8'hF7);
    #3 rstn = 1'b1;
    fv0 = fv_cnt; scan(base, 20, -1); hold(base[63:56], 8'h7F, 4);
    check_frame("t6", fv0, 32'h87654321, 8'h00, 1'b0);

    // Randomized scans: mixed patterns, short dwells, glitches, occasional freezes.
    pls_mode = 1;
    for (int n = 0; n < 40; n++) begin
      for (int d = 0; d < 8; d++) begin
        int r;
        r = $urandom_range(0, 15);
        if (r <= 10) rnd[8*d +: 8] = enc(r);
        else rnd[8*d +: 8] = 8'($urandom_range(0, 127));
        rnd[8*d + 7] = 1'($urandom_range(0, 1));
      end
      scan(rnd, $urandom_range(3, 14), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1);
      if ($urandom_range(0, 9) == 0) begin
        pls_mode = 2; hold(rnd[63:56], 8'h7F, 40); pls_mode = 1;
      end
    end
    hold(8'h00, 8'hFF, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
